// File: rtl/pcie_axi_ingress_arbiter_if.sv
// pcie_axi_ingress_arbiter_if: 32-bit AXI-Stream beat with keep/last and ready backpressure
interface pcie_axi_ingress_arbiter_if;
  logic [31:0] data;
  logic [3:0]  keep;
  logic        valid;
  logic        last;
  logic        ready;
  modport master (output data, keep, valid, last, input ready);
  modport slave (input data, keep, valid, last, output ready);
endinterface

// File: rtl/pcie_axi_ingress_arbiter.sv
// pcie_axi_ingress_arbiter: packet-locked round-robin share of one 32-bit AXI-Stream between two requesters
module pcie_axi_ingress_arbiter #(
  parameter int MAX_BEATS = 256,
  parameter int CNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    i_enable,
  input  logic                          i_clear_err,
  pcie_axi_ingress_arbiter_if.slave     a,
  pcie_axi_ingress_arbiter_if.slave     b,
  pcie_axi_ingress_arbiter_if.master    out32,
  output logic [1:0]                    o_grant,
  output logic                          o_busy,
  output logic [CNT_WIDTH-1:0]          o_pkt_count,
  output logic                          o_len_err
);
  localparam int BW = $clog2(MAX_BEATS + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        state;
  logic          rr;
  logic [BW-1:0] beat_cnt;
  logic          el_a, el_b, sel_b, own_b, busy, acc;
  assign busy  = state == BUSY;
  assign own_b = o_grant[1];
  assign el_a  = a.valid & i_enable[0];
  assign el_b  = b.valid & i_enable[1];
  // rr high means B wins a tie
  assign sel_b = el_b & (~el_a | rr);
  assign out32.data  = busy ? (own_b ? b.data : a.data) : '0;
  assign out32.keep  = busy ? (own_b ? b.keep : a.keep) : '0;
  assign out32.last  = busy & (own_b ? b.last : a.last);
  assign out32.valid = busy & (own_b ? b.valid : a.valid);
  assign a.ready = busy & ~own_b & out32.ready;
  assign b.ready = busy & own_b & out32.ready;
  assign acc     = out32.valid & out32.ready;
  assign o_busy  = busy;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      o_grant     <= '0;
      rr          <= 1'b0;
      beat_cnt    <= '0;
      o_pkt_count <= '0;
      o_len_err   <= 1'b0;
    end else begin
      if (i_clear_err) o_len_err <= 1'b0;
      if (state == IDLE) begin
        beat_cnt <= '0;
        if (el_a | el_b) begin
          state   <= BUSY;
          o_grant <= sel_b ? 2'b10 : 2'b01;
        end
      end else if (acc) begin
        if (beat_cnt != BW'(MAX_BEATS)) beat_cnt <= beat_cnt + BW'(1);
        if (out32.last) begin
          state       <= IDLE;
          o_grant     <= '0;
          rr          <= ~own_b;
          o_pkt_count <= o_pkt_count + CNT_WIDTH'(1);
        end else if (beat_cnt == BW'(MAX_BEATS - 1)) begin
          o_len_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pcie_axi_ingress_arbiter.sv
// tb_pcie_axi_ingress_arbiter: directed checks of arbitration, pass-through, backpressure, length error and reset
module tb_pcie_axi_ingress_arbiter;
  localparam int MAXB = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  en = 2'b11;
  logic        clr = 1'b0;
  logic [1:0]  grant;
  logic        busy;
  logic [31:0] pkt;
  logic        len_err;
  int          checks = 0;
  int          errors = 0;
  int          beat;
  pcie_axi_ingress_arbiter_if a_if();
  pcie_axi_ingress_arbiter_if b_if();
  pcie_axi_ingress_arbiter_if o_if();
  pcie_axi_ingress_arbiter #(.MAX_BEATS(MAXB), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_enable(en), .i_clear_err(clr),
    .a(a_if), .b(b_if), .out32(o_if),
    .o_grant(grant), .o_busy(busy), .o_pkt_count(pkt), .o_len_err(len_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic a_pkt(input int n, input logic [31:0] base, input int clr_at, input logic prior);
    a_if.valid = 1'b1;
    a_if.data  = base;
    a_if.last  = 1'b0;
    #1;
    chk("idle_grant", 32'(grant), 0);
    chk("idle_a_ready", 32'(a_if.ready), 0);
    chk("idle_zero_data", o_if.data, 0);
    chk("idle_zero_keep", 32'(o_if.keep), 0);
    tick();
    for (int j = 0; j < n; j++) begin
      a_if.data = base + 32'(j);
      a_if.last = (j == n - 1);
      clr = (j == clr_at);
      #1;
      chk("pkt_grant", 32'(grant), 1);
      chk("pkt_data", o_if.data, base + 32'(j));
      chk("pkt_keep", 32'(o_if.keep), 32'h5);
      chk("pkt_last", 32'(o_if.last), 32'(j == n - 1));
      chk("pkt_a_ready", 32'(a_if.ready), 1);
      chk("pkt_b_ready", 32'(b_if.ready), 0);
      chk("pkt_len_err", 32'(len_err), j >= MAXB ? 1 : 32'(prior));
      tick();
    end
    a_if.valid = 1'b0;
    a_if.last  = 1'b0;
    clr = 1'b0;
    #1;
    chk("post_grant", 32'(grant), 0);
  endtask
  initial begin
    a_if.valid = 0; a_if.last = 0; a_if.data = 0; a_if.keep = 4'h5;
    b_if.valid = 0; b_if.last = 0; b_if.data = 0; b_if.keep = 4'hA;
    o_if.ready = 1'b1;
    tick();
    tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pkt", pkt, 0);
    chk("rst_len_err", 32'(len_err), 0);
    chk("rst_valid", 32'(o_if.valid), 0);
    chk("rst_a_ready", 32'(a_if.ready), 0);
    chk("rst_b_ready", 32'(b_if.ready), 0);
    rst = 1'b0;
    // single A packet
    a_pkt(4, 32'hA1000000, -1, 1'b0);
    chk("t1_pkt", pkt, 1);
    chk("t1_busy", 32'(busy), 0);
    // round robin with both requesters waiting from reset exit
    rst = 1'b1;
    a_if.valid = 1'b1;
    b_if.valid = 1'b1;
    tick();
    chk("t2_rst_grant", 32'(grant), 0);
    chk("t2_rst_pkt", pkt, 0);
    tick();
    rst = 1'b0;
    for (int p = 0; p < 4; p++) begin
      a_if.valid = (p < 3);
      b_if.valid = 1'b1;
      a_if.data = 32'hA2000000 + 32'(p * 256);
      b_if.data = 32'hB2000000 + 32'(p * 256);
      #1;
      chk("rr_idle_grant", 32'(grant), 0);
      chk("rr_idle_valid", 32'(o_if.valid), 0);
      chk("rr_idle_last", 32'(o_if.last), 0);
      tick();
      for (int j = 0; j < 2; j++) begin
        if (p % 2 == 1) begin
          b_if.data = 32'hB2000000 + 32'(p * 256 + j);
          b_if.last = (j == 1);
        end else begin
          a_if.data = 32'hA2000000 + 32'(p * 256 + j);
          a_if.last = (j == 1);
        end
        #1;
        chk("rr_grant", 32'(grant), p % 2 == 1 ? 2 : 1);
        chk("rr_data", o_if.data, (p % 2 == 1 ? 32'hB2000000 : 32'hA2000000) + 32'(p * 256 + j));
        chk("rr_keep", 32'(o_if.keep), p % 2 == 1 ? 32'hA : 32'h5);
        chk("rr_last", 32'(o_if.last), 32'(j == 1));
        chk("rr_nonowner_ready", 32'(p % 2 == 1 ? a_if.ready : b_if.ready), 0);
        tick();
      end
    end
    a_if.valid = 0; b_if.valid = 0; a_if.last = 0; b_if.last = 0;
    #1;
    chk("t2_pkt", pkt, 4);
    chk("t2_grant", 32'(grant), 0);
    // toggling downstream ready, B waiting but pointer favours A
    a_if.valid = 1'b1; a_if.data = 32'hC3000000;
    b_if.valid = 1'b1; b_if.data = 32'hB3000000;
    #1;
    chk("t3_idle_grant", 32'(grant), 0);
    tick();
    beat = 0;
    for (int k = 0; k < 10 && beat < 3; k++) begin
      o_if.ready = (k % 2 == 0);
      a_if.data = 32'hC3000000 + 32'(beat);
      a_if.last = (beat == 2);
      #1;
      chk("tog_b_ready", 32'(b_if.ready), 0);
      chk("tog_grant", 32'(grant), 1);
      chk("tog_data", o_if.data, 32'hC3000000 + 32'(beat));
      chk("tog_a_ready", 32'(a_if.ready), 32'(o_if.ready));
      if (o_if.ready) beat++;
      tick();
    end
    a_if.valid = 0; b_if.valid = 0; a_if.last = 0; o_if.ready = 1'b1;
    #1;
    chk("t3_beats", 32'(beat), 3);
    chk("t3_grant", 32'(grant), 0);
    chk("t3_pkt", pkt, 5);
    // over-length packets, sticky error, clear, and error beating a simultaneous clear
    a_pkt(6, 32'hD4000000, -1, 1'b0);
    chk("t4_len_err", 32'(len_err), 1);
    chk("t4_pkt", pkt, 6);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    chk("t4_cleared", 32'(len_err), 0);
    a_pkt(5, 32'hD5000000, 3, 1'b0);
    chk("t4_err_wins", 32'(len_err), 1);
    chk("t4_pkt2", pkt, 7);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    chk("t4_cleared2", 32'(len_err), 0);
    // enable masking
    en = 2'b10;
    a_if.valid = 1; a_if.data = 32'hE5000000; a_if.last = 0;
    b_if.valid = 1; b_if.data = 32'hF5000000; b_if.last = 0;
    #1;
    chk("t5_idle_grant", 32'(grant), 0);
    tick();
    chk("t5_grant_b", 32'(grant), 2);
    chk("t5_a_ready", 32'(a_if.ready), 0);
    chk("t5_data0", o_if.data, 32'hF5000000);
    tick();
    b_if.data = 32'hF5000001; b_if.last = 1;
    #1;
    chk("t5_data1", o_if.data, 32'hF5000001);
    tick();
    b_if.valid = 0; b_if.last = 0;
    #1;
    chk("t5_after_b", 32'(grant), 0);
    tick();
    chk("t5_a_masked", 32'(grant), 0);
    en = 2'b11;
    tick();
    chk("t5_grant_a", 32'(grant), 1);
    chk("t5_a_data0", o_if.data, 32'hE5000000);
    en = 2'b00;
    tick();
    a_if.data = 32'hE5000001; a_if.last = 1;
    #1;
    chk("t5_hold_grant", 32'(grant), 1);
    chk("t5_a_data1", o_if.data, 32'hE5000001);
    tick();
    a_if.valid = 0; a_if.last = 0; en = 2'b11;
    #1;
    chk("t5_pkt", pkt, 9);
    // reset mid-packet
    a_if.valid = 1; a_if.data = 32'h66000000;
    #1;
    chk("t6_idle_grant", 32'(grant), 0);
    tick();
    tick();
    a_if.data = 32'h66000001;
    #1;
    chk("t6_beat1", o_if.data, 32'h66000001);
    tick();
    a_if.data = 32'h66000002;
    rst = 1'b1;
    tick();
    chk("t6_rst_grant", 32'(grant), 0);
    chk("t6_rst_valid", 32'(o_if.valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_pkt", pkt, 0);
    chk("t6_rst_a_ready", 32'(a_if.ready), 0);
    rst = 1'b0;
    a_if.valid = 0;
    b_if.valid = 1; b_if.data = 32'h77000000; b_if.last = 0;
    #1;
    chk("t6_idle", 32'(grant), 0);
    tick();
    chk("t6_grant_b", 32'(grant), 2);
    chk("t6_b_data0", o_if.data, 32'h77000000);
    tick();
    b_if.data = 32'h77000001; b_if.last = 1;
    #1;
    chk("t6_b_last", 32'(o_if.last), 1);
    tick();
    b_if.valid = 0; b_if.last = 0;
    #1;
    chk("t6_pkt", pkt, 1);
    chk("t6_end_grant", 32'(grant), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
